// File: rtl/gpio_regs_if.sv
// Bus-side view of the GPIO register block: byte address, write strobe, size, data.
// Port summary: addr/wen/byt/wdata driven by the CPU side; rdata/hit returned registered.
// Modports: master = CPU data-memory bus side, slave = gpio_regs.
interface gpio_regs_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic              byt;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              hit;

  modport master (output addr, wen, byt, wdata, input rdata, hit);
  modport slave  (input addr, wen, byt, wdata, output rdata, hit);
endinterface

// File: rtl/gpio_regs.sv
// Purpose: memory-mapped GPIO block, NPORT 8-bit ports with OUT/DIR/IN/ISR/IE_R/IE_F registers and one level irq.
// Latency: writes land on the wen edge; rdata/hit one cycle after addr; pin edge -> IN 2 cycles, -> ISR 3, -> irq 4.
// Backpressure: none; the bus is accepted every cycle, misses return 0 with hit=0.
// Ports: sys_clk, rst_n (async, active-low), bus (gpio_regs_if.slave), gpio_out/gpio_oe (port 0 in [7:0]),
//        gpio_in (raw async pins), irq (registered OR of all ISR bits).
// Optional: define GPIO_DEBOUNCE_EN to insert a DEBOUNCE_CYC-cycle debouncer per input bit after the synchroniser.
module gpio_regs #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 'h080,
  parameter int NPORT     = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  gpio_regs_if.slave           bus,
  output logic [8*NPORT-1:0]   gpio_out,
  output logic [8*NPORT-1:0]   gpio_oe,
  input  logic [8*NPORT-1:0]   gpio_in,
  output logic                 irq
);
  localparam int PW = 8 * NPORT;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WIN  = ADDR_W'(6 * NPORT);

  logic [NPORT-1:0][7:0] out_q, out_d, dir_q, dir_d;
  logic [NPORT-1:0][7:0] ier_q, ier_d, ief_q, ief_d, isr_q, isr_d;
  logic [PW-1:0]         sync1_q, sync2_q, prev_q, in_val, rise, fall;
  logic [15:0]           rdata_q, rdata_d;
  logic                  hit_q, hit_d, irq_q, irq_d;
  logic [ADDR_W-1:0]     off;
  logic [31:0]           widx;
  logic                  wr_even, wr_odd;

  // The addr >= BASE term guards against the subtraction wrapping below the window.
  assign off   = bus.addr - BASE;
  assign hit_d = (bus.addr >= BASE) && (off < WIN);
  assign widx  = 32'(off[ADDR_W-1:1]);

  // Word writes touch both bytes regardless of addr[0]; the even byte always
  // takes wdata[7:0] and the odd byte wdata[15:8].
  assign wr_even = bus.wen && hit_d && (!bus.byt || !bus.addr[0]);
  assign wr_odd  = bus.wen && hit_d && (!bus.byt ||  bus.addr[0]);

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [PW-1:0][CW-1:0] cnt_q;
  logic [PW-1:0]         deb_q;

  // IN follows the synchroniser only after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= '0;
    end else begin
      for (int b = 0; b < PW; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (cnt_q[b] == CW'(DEBOUNCE_CYC - 1)) begin
            deb_q[b] <= sync2_q[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + 1'b1;
          end
        end else begin
          cnt_q[b] <= '0;
        end
      end
    end
  end
  assign in_val = deb_q;
`else
  assign in_val = sync2_q;
`endif

  assign rise = in_val & ~prev_q;
  assign fall = ~in_val & prev_q;

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ier_d   = ier_q;
    ief_d   = ief_q;
    isr_d   = isr_q;
    rdata_d = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (hit_d && widx == 32'(p)) begin
        if (wr_even) out_d[p] = bus.wdata[7:0];
        if (wr_odd)  dir_d[p] = bus.wdata[15:8];
        rdata_d = {dir_q[p], out_q[p]};
      end
      if (hit_d && widx == 32'(NPORT + p)) begin
        rdata_d = {isr_q[p], in_val[8*p +: 8]};
      end
      if (hit_d && widx == 32'(2*NPORT + p)) begin
        if (wr_even) ier_d[p] = bus.wdata[7:0];
        if (wr_odd)  ief_d[p] = bus.wdata[15:8];
        rdata_d = {ief_q[p], ier_q[p]};
      end
      // Clear first, then OR in new events so a same-cycle set beats the W1C.
      isr_d[p] = (isr_q[p] & ~((wr_odd && widx == 32'(NPORT + p)) ? bus.wdata[15:8] : 8'h00))
               | (rise[8*p +: 8] & ier_q[p])
               | (fall[8*p +: 8] & ief_q[p]);
    end
  end

  assign irq_d = |isr_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      dir_q   <= '0;
      ier_q   <= '0;
      ief_q   <= '0;
      isr_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ier_q   <= ier_d;
      ief_q   <= ief_d;
      isr_q   <= isr_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      prev_q  <= in_val;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.hit   = hit_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_gpio_regs.sv
// Directed bench for gpio_regs with NPORT=2, BASE_ADDR='h080: a vector table for
// register access plus hand sequences for input latency, ISR/irq timing and async reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_gpio_regs;
  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [15:0] gpio_out, gpio_oe, gpio_in;
  logic        irq;
  int          n_tests = 0;
  int          n_fail  = 0;

  gpio_regs_if #(.ADDR_W(10)) bus ();

  gpio_regs #(.ADDR_W(10), .BASE_ADDR('h080), .NPORT(2)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        wen;
    logic        byt;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vt[18];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_drive(input logic w, input logic b, input logic [9:0] a, input logic [15:0] d);
    bus.wen   = w;
    bus.byt   = b;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  initial begin
    // wen byt addr wdata -> rdata (old contents on a write cycle), hit
    vt[0]  = '{1'b0, 1'b0, 10'h080, 16'h0000, 16'h0000, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 10'h08A, 16'h0000, 16'h0000, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 10'h082, 16'h5AA5, 16'h0000, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 10'h082, 16'h0000, 16'h5AA5, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 10'h081, 16'h3C00, 16'h0000, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 10'h080, 16'h0000, 16'h3C00, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 10'h082, 16'h0000, 16'h5AA5, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 10'h080, 16'h00C3, 16'h3C00, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 10'h080, 16'h0000, 16'h3CC3, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 10'h08C, 16'hFFFF, 16'h0000, 1'b0};
    vt[10] = '{1'b0, 1'b0, 10'h08C, 16'h0000, 16'h0000, 1'b0};
    vt[11] = '{1'b0, 1'b0, 10'h07F, 16'h0000, 16'h0000, 1'b0};
    vt[12] = '{1'b1, 1'b0, 10'h089, 16'h1234, 16'h0000, 1'b1};
    vt[13] = '{1'b0, 1'b0, 10'h088, 16'h0000, 16'h1234, 1'b1};
    vt[14] = '{1'b1, 1'b0, 10'h088, 16'h0000, 16'h1234, 1'b1};
    vt[15] = '{1'b1, 1'b0, 10'h084, 16'hFFFF, 16'h0000, 1'b1};
    vt[16] = '{1'b0, 1'b0, 10'h084, 16'h0000, 16'h0000, 1'b1};
    vt[17] = '{1'b0, 1'b0, 10'h08B, 16'h0000, 16'h0000, 1'b1};

    rst_n   = 1'b0;
    gpio_in = 16'h0000;
    bus_drive(1'b0, 1'b0, 10'h000, 16'h0000);
    #12;
    chk("rst gpio_out", 32'(gpio_out), 32'h0);
    chk("rst gpio_oe",  32'(gpio_oe),  32'h0);
    chk("rst irq",      32'(irq),      32'h0);
    chk("rst rdata",    32'(bus.rdata), 32'h0);
    chk("rst hit",      32'(bus.hit),  32'h0);
    rst_n = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 18; i++) begin
      bus_drive(vt[i].wen, vt[i].byt, vt[i].addr, vt[i].wdata);
      tick();
      bus.wen = 1'b0;
      chk($sformatf("vec%0d rdata", i), 32'(bus.rdata), 32'(vt[i].exp_rd));
      chk($sformatf("vec%0d hit", i),   32'(bus.hit),   32'(vt[i].exp_hit));
    end
    chk("gpio_out", 32'(gpio_out), 32'h0000A5C3);
    chk("gpio_oe",  32'(gpio_oe),  32'h00005A3C);

    // Input synchroniser latency and IN read-only
    gpio_in = 16'h0081;
    bus_drive(1'b0, 1'b0, 10'h084, 16'h0000);
    tick(); tick();
    chk("in_lat2", 32'(bus.rdata), 32'h0000);
    tick();
    chk("in_lat3", 32'(bus.rdata), 32'h0081);
    bus_drive(1'b1, 1'b0, 10'h084, 16'h0000);
    tick();
    bus.wen = 1'b0;
    tick();
    chk("in_ro", 32'(bus.rdata), 32'h0081);

    // Enabling IE_R0 after the edge must not latch the old rise
    bus_drive(1'b1, 1'b1, 10'h088, 16'h0001);
    tick();
    bus_drive(1'b0, 1'b0, 10'h084, 16'h0000);
    tick(); tick();
    chk("edge_lost rdata", 32'(bus.rdata), 32'h0081);
    chk("edge_lost irq",   32'(irq),       32'h0);
    gpio_in = 16'h0000;
    repeat (4) tick();

    // Rise on pin 0 with IE_R0=1: ISR at 3rd edge, irq at 4th
    gpio_in = 16'h0001;
    tick(); tick(); tick();
    chk("rise irq_pre", 32'(irq), 32'h0);
    tick();
    chk("rise isr",  32'(bus.rdata), 32'h0101);
    chk("rise irq",  32'(irq),       32'h1);
    bus_drive(1'b1, 1'b1, 10'h085, 16'h0100);
    tick();
    bus_drive(1'b0, 1'b0, 10'h084, 16'h0000);
    chk("w1c irq_hold", 32'(irq), 32'h1);
    tick();
    chk("w1c isr", 32'(bus.rdata), 32'h0001);
    chk("w1c irq", 32'(irq),       32'h0);

    // Fall on pin 15 colliding with a W1C of the same bit: set wins
    gpio_in = 16'h8001;
    repeat (4) tick();
    bus_drive(1'b1, 1'b1, 10'h08B, 16'h8000);
    tick();
    bus.wen = 1'b0;
    gpio_in = 16'h0001;
    tick(); tick();
    bus_drive(1'b1, 1'b1, 10'h087, 16'h8000);
    tick();
    bus_drive(1'b0, 1'b0, 10'h086, 16'h0000);
    tick();
    chk("set_wins isr", 32'(bus.rdata), 32'h8000);
    tick();
    chk("set_wins irq", 32'(irq), 32'h1);
    bus_drive(1'b1, 1'b1, 10'h08B, 16'h0000);
    tick();
    bus_drive(1'b0, 1'b0, 10'h086, 16'h0000);
    tick();
    chk("ie_clr_keeps isr", 32'(bus.rdata), 32'h8000);
    bus_drive(1'b1, 1'b1, 10'h087, 16'h8000);
    tick();
    bus_drive(1'b0, 1'b0, 10'h086, 16'h0000);
    tick();
    chk("w1c1 isr", 32'(bus.rdata), 32'h0000);
    chk("w1c1 irq", 32'(irq),       32'h0);

    // Pend a fall on pin 0, then async reset mid-cycle
    bus_drive(1'b1, 1'b0, 10'h088, 16'h0101);
    tick();
    bus_drive(1'b0, 1'b0, 10'h080, 16'h0000);
    gpio_in = 16'h0000;
    repeat (5) tick();
    chk("pre_rst irq",   32'(irq),       32'h1);
    chk("pre_rst rdata", 32'(bus.rdata), 32'h3CC3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst gpio_out", 32'(gpio_out),  32'h0);
    chk("arst gpio_oe",  32'(gpio_oe),   32'h0);
    chk("arst irq",      32'(irq),       32'h0);
    chk("arst rdata",    32'(bus.rdata), 32'h0);
    chk("arst hit",      32'(bus.hit),   32'h0);
    #2;
    rst_n   = 1'b1;
    gpio_in = 16'h0081;
    repeat (3) tick();
    for (int w = 0; w < 6; w++) begin
      bus_drive(1'b0, 1'b0, 10'(10'h080 + 2*w), 16'h0000);
      tick();
      chk($sformatf("post_rst word%0d", w), 32'(bus.rdata), (w == 2) ? 32'h0081 : 32'h0);
    end
    chk("post_rst irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
